ro_freq_counter: RTL



---
 rtl/ro_freq_pkg.sv | 31 +++
 rtl/ro_freq_counter_sync_edge.sv | 59 +++++
 rtl/ro_freq_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ro_freq_pkg.sv
// Shared types and helpers for the ring-oscillator frequency counter.
// ARM length depends on RO_FREQ_GLITCH_FILTER_EN (filter flush time).
package ro_freq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        HOLD
    } ro_state_t;

    localparam int DEF_WIN_W = 16;
    localparam int DEF_CNT_W = 20;

`ifdef RO_FREQ_GLITCH_FILTER_EN
    localparam int ARM_CYCLES = 3;
`else
    localparam int ARM_CYCLES = 1;
`endif

    function automatic logic [31:0] sat_inc(
        input logic [31:0] value,
        input int          width
    );
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF
                              : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/ro_freq_counter_sync_edge.sv
// OSC_IN synchronizer, optional glitch filter and rising-edge detector.
// Filter is built when RO_FREQ_GLITCH_FILTER_EN is defined.
module ro_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic osc_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   dly_q;
    logic                   edge_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
        end
    end

`ifdef RO_FREQ_GLITCH_FILTER_EN
    logic prev_q;
    logic filt_q;

    // Level follows the synchronizer only once two samples agree.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
            if (sync_q[SYNC_STAGES-1] == prev_q) begin
                filt_q <= prev_q;
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dly_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            dly_q  <= level;
            edge_q <= level & ~dly_q;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator edge counter over a programmable CLK window.
// Optional glitch filter: define RO_FREQ_GLITCH_FILTER_EN.
module ro_freq_counter
    import ro_freq_pkg::*;
#(
    parameter int WIN_W       = DEF_WIN_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN_CYCLES,
    input  logic             OSC_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ro_state_t        state_q;
    ro_state_t        state_d;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [CNT_W-1:0] edge_cnt_d;
    logic             ovf_acc_q;
    logic             ovf_acc_d;
    logic [1:0]       arm_cnt_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             done_q;
    logic             busy_q;
    logic             edge_pulse;
    logic             load;
    logic             count_en;
    logic             finish;
    logic             arm_last;

    ro_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .CLK       (CLK),
        .RST       (RST),
        .osc_in    (OSC_IN),
        .edge_pulse(edge_pulse)
    );

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_acc_d  = ovf_acc_q;
        if (edge_pulse) begin
            edge_cnt_d = CNT_W'(sat_inc(32'(edge_cnt_q), CNT_W));
            ovf_acc_d  = ovf_acc_q | (edge_cnt_q == CNT_MAX);
        end
    end

    assign arm_last = (arm_cnt_q == 2'(ARM_CYCLES - 1));

    // done_q blocks a START landing on the DONE cycle.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        count_en = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            IDLE, HOLD: begin
                if (START && !done_q) begin
                    load    = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (arm_last) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                count_en = 1'b1;
                if (win_q == WIN_W'(1)) begin
                    finish  = 1'b1;
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            win_q      <= '0;
            edge_cnt_q <= '0;
            ovf_acc_q  <= 1'b0;
            arm_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                win_q      <= (WIN_CYCLES == '0) ? WIN_W'(1) : WIN_CYCLES;
                edge_cnt_q <= '0;
                ovf_acc_q  <= 1'b0;
                arm_cnt_q  <= '0;
            end else begin
                if (state_q == ARM) begin
                    arm_cnt_q <= arm_cnt_q + 2'd1;
                end
                if (count_en) begin
                    win_q      <= win_q - WIN_W'(1);
                    edge_cnt_q <= edge_cnt_d;
                    ovf_acc_q  <= ovf_acc_d;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                busy_q <= 1'b1;
            end
            // Final-cycle edge is folded in via edge_cnt_d.
            if (finish) begin
                count_q <= edge_cnt_d;
                ovf_q   <= ovf_acc_d;
                busy_q  <= 1'b0;
            end
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign COUNT = count_q;
    assign OVF   = ovf_q;

endmodule
